ahb_line_fetch: RTL and testbench

- AHB-Lite read master directly downstream of the I-cache miss path.
- Accepts a line-refill request (cache mem_req/mem_addr), issues one 4-beat 32-bit read burst on AHB-Lite, and assembles the beats into a 128-bit line.
- Returns the line to the cache via line_data/line_ready, which connect to mem_data_in/mem_ready.
- Read-only: HWRITE is tied low.

---
 rtl/ahb_line_fetch_if.sv | 31 +++
 rtl/ahb_line_fetch.sv | 148 ++++++++++++++
 tb/tb_ahb_line_fetch.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_line_fetch_if.sv
// Refill request/line return plus AHB-Lite read-master signals for
// the I-cache line fetch unit.
interface ahb_line_fetch_if;
    logic         req;
    logic [31:0]  req_addr;
    logic [127:0] line_data;
    logic         line_ready;
    logic         err;
    logic         busy;
    logic [31:0]  HADDR;
    logic [1:0]   HTRANS;
    logic [2:0]   HBURST;
    logic [2:0]   HSIZE;
    logic         HWRITE;
    logic [3:0]   HPROT;
    logic [31:0]  HRDATA;
    logic         HREADY;
    logic         HRESP;

    modport master (
        input  req, req_addr, HRDATA, HREADY, HRESP,
        output line_data, line_ready, err, busy,
        output HADDR, HTRANS, HBURST, HSIZE, HWRITE, HPROT
    );

    modport slave (
        output req, req_addr, HRDATA, HREADY, HRESP,
        input  line_data, line_ready, err, busy,
        input  HADDR, HTRANS, HBURST, HSIZE, HWRITE, HPROT
    );
endinterface

// File: rtl/ahb_line_fetch.sv
// I-cache refill master: one 4-beat AHB-Lite read burst per miss,
// beats assembled by address into a 128-bit line.
module ahb_line_fetch #(
    parameter bit         WRAP_EN   = 1'b0,
    parameter logic [3:0] HPROT_VAL = 4'b0010
) (
    input logic              clk,
    input logic              rst,
    ahb_line_fetch_if.master bus
);
    typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;

    localparam logic [1:0] HT_IDLE   = 2'b00;
    localparam logic [1:0] HT_NONSEQ = 2'b10;
    localparam logic [1:0] HT_SEQ    = 2'b11;
    localparam logic [2:0] HB_VAL    = WRAP_EN ? 3'b010 : 3'b011;

    state_t       state_q, state_d;
    logic [31:0]  haddr_q, haddr_d;
    logic [1:0]   htrans_q, htrans_d;
    logic [2:0]   hburst_q, hburst_d;
    logic [1:0]   abeat_q, abeat_d;
    logic [1:0]   dbeat_q, dbeat_d;
    logic         dphase_q, dphase_d;
    logic [1:0]   dword_q, dword_d;
    logic [127:0] line_q, line_d;
    logic         ready_q, ready_d;
    logic         err_q, err_d;
    logic [31:0]  next_addr;
    logic         unused_addr_lsb;

    assign unused_addr_lsb = ^bus.req_addr[1:0];

    // WRAP4 keeps the line base; INCR4 starts aligned so +4 never leaves it
    assign next_addr = WRAP_EN
        ? {haddr_q[31:4], haddr_q[3:2] + 2'd1, 2'b00}
        : haddr_q + 32'd4;

    always_comb begin
        state_d  = state_q;
        haddr_d  = haddr_q;
        htrans_d = htrans_q;
        hburst_d = hburst_q;
        abeat_d  = abeat_q;
        dbeat_d  = dbeat_q;
        dphase_d = dphase_q;
        dword_d  = dword_q;
        line_d   = line_q;
        ready_d  = ready_q;
        err_d    = err_q;
        unique case (state_q)
            IDLE: begin
                if (bus.req) begin
                    haddr_d  = WRAP_EN ? {bus.req_addr[31:2], 2'b00}
                                       : {bus.req_addr[31:4], 4'h0};
                    htrans_d = HT_NONSEQ;
                    hburst_d = HB_VAL;
                    abeat_d  = 2'd0;
                    dbeat_d  = 2'd0;
                    dphase_d = 1'b0;
                    state_d  = BURST;
                end
            end
            BURST: begin
                if (!bus.HREADY) begin
                    // first ERROR cycle: cancel the pending address phase
                    if (dphase_q && bus.HRESP) htrans_d = HT_IDLE;
                end else begin
                    if (htrans_q != HT_IDLE) begin
                        dphase_d = 1'b1;
                        dword_d  = haddr_q[3:2];
                        if (abeat_q == 2'd3) begin
                            htrans_d = HT_IDLE;
                        end else begin
                            htrans_d = HT_SEQ;
                            haddr_d  = next_addr;
                            abeat_d  = abeat_q + 2'd1;
                        end
                    end else begin
                        dphase_d = 1'b0;
                    end
                    if (dphase_q) begin
                        if (!bus.HRESP) begin
                            line_d[32*dword_q +: 32] = bus.HRDATA;
                            dbeat_d = dbeat_q + 2'd1;
                        end
                        if (bus.HRESP || dbeat_q == 2'd3) begin
                            state_d  = bus.req ? DONE : IDLE;
                            ready_d  = bus.req;
                            err_d    = bus.req & bus.HRESP;
                            htrans_d = HT_IDLE;
                            dphase_d = 1'b0;
                            abeat_d  = 2'd0;
                            dbeat_d  = 2'd0;
                        end
                    end
                end
            end
            DONE: begin
                if (!bus.req) begin
                    state_d = IDLE;
                    ready_d = 1'b0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            haddr_q  <= '0;
            htrans_q <= HT_IDLE;
            hburst_q <= '0;
            abeat_q  <= '0;
            dbeat_q  <= '0;
            dphase_q <= 1'b0;
            dword_q  <= '0;
            line_q   <= '0;
            ready_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            haddr_q  <= haddr_d;
            htrans_q <= htrans_d;
            hburst_q <= hburst_d;
            abeat_q  <= abeat_d;
            dbeat_q  <= dbeat_d;
            dphase_q <= dphase_d;
            dword_q  <= dword_d;
            line_q   <= line_d;
            ready_q  <= ready_d;
            err_q    <= err_d;
        end
    end

    assign bus.HADDR      = haddr_q;
    assign bus.HTRANS     = htrans_q;
    assign bus.HBURST     = hburst_q;
    assign bus.HSIZE      = 3'b010;
    assign bus.HWRITE     = 1'b0;
    assign bus.HPROT      = HPROT_VAL;
    assign bus.line_data  = line_q;
    assign bus.line_ready = ready_q;
    assign bus.err        = err_q;
    assign bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_ahb_line_fetch.sv
// Directed bench: INCR4 and WRAP4 instances behind one scripted
// AHB slave; checks address sequence, line assembly, errors, reset.
module tb_ahb_line_fetch;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ahb_line_fetch_if bus0();
    ahb_line_fetch_if bus1();

    ahb_line_fetch #(.WRAP_EN(1'b0), .HPROT_VAL(4'b0010)) u_incr (
        .clk(clk), .rst(rst), .bus(bus0)
    );
    ahb_line_fetch #(.WRAP_EN(1'b1), .HPROT_VAL(4'b0010)) u_wrap (
        .clk(clk), .rst(rst), .bus(bus1)
    );

    logic        sel, req, hready, hresp;
    logic [31:0] req_addr, hrdata;

    assign bus0.req      = req & ~sel;
    assign bus1.req      = req & sel;
    assign bus0.req_addr = req_addr;
    assign bus1.req_addr = req_addr;
    assign bus0.HRDATA   = hrdata;
    assign bus1.HRDATA   = hrdata;
    assign bus0.HREADY   = hready;
    assign bus1.HREADY   = hready;
    assign bus0.HRESP    = hresp;
    assign bus1.HRESP    = hresp;

    logic [31:0]  haddr;
    logic [1:0]   htrans;
    logic [2:0]   hburst;
    logic [127:0] line;
    logic         lr, errs, busy;

    assign haddr  = sel ? bus1.HADDR      : bus0.HADDR;
    assign htrans = sel ? bus1.HTRANS     : bus0.HTRANS;
    assign hburst = sel ? bus1.HBURST     : bus0.HBURST;
    assign line   = sel ? bus1.line_data  : bus0.line_data;
    assign lr     = sel ? bus1.line_ready : bus0.line_ready;
    assign errs   = sel ? bus1.err        : bus0.err;
    assign busy   = sel ? bus1.busy       : bus0.busy;

    int n_chk = 0;
    int n_pass = 0;
    logic [31:0] ta [40];
    logic [1:0]  tt [40];
    logic [2:0]  tbu[40];
    int lat, nb, kend;

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Scripted slave: wb/wn = wait-stalled beat and count, eb = ERROR beat,
    // drop = cycle to release req, stop = cycle to abandon the run.
    task automatic run(input logic [31:0] a, input logic [31:0] base,
                       input int wb, input int wn, input int eb,
                       input int drop, input int stop);
        logic        dv;
        logic [31:0] da;
        logic [31:0] ca;
        logic [1:0]  ct;
        int di, wl, ep;
        dv = 1'b0; da = '0; di = 0; wl = wn; ep = 0;
        nb = 0; lat = -1; kend = -1;
        req = 1'b1;
        req_addr = a;
        @(posedge clk);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            ta[k]  = haddr;
            tt[k]  = htrans;
            tbu[k] = hburst;
            if (k == drop) req = 1'b0;
            if (lr) begin
                lat = k; kend = k;
                break;
            end
            if (!busy || k == stop) begin
                kend = k;
                break;
            end
            hready = 1'b1;
            hresp  = 1'b0;
            hrdata = 32'hDEAD_BEEF;
            if (dv) begin
                if (di == eb) begin
                    hready = (ep != 0);
                    hresp  = 1'b1;
                end else if (di == wb && wl > 0) begin
                    hready = 1'b0;
                end else begin
                    hrdata = base + {30'd0, da[3:2]};
                end
            end
            ct = htrans;
            ca = haddr;
            @(posedge clk);
            if (hready) begin
                dv = ct[1];
                da = ca;
                if (ct[1]) begin
                    di = nb;
                    nb++;
                end
            end else if (dv && di == eb) begin
                ep = 1;
            end else begin
                wl--;
            end
        end
        hready = 1'b1;
        hresp  = 1'b0;
    endtask

    task automatic end_req(input string tag);
        req = 1'b0;
        @(negedge clk);
        check({tag, "_rdy_clr"}, lr, 1'b0);
        check({tag, "_idle"}, busy, 1'b0);
    endtask

    logic [31:0] wrap_exp [4];

    initial begin
        wrap_exp[0] = 32'h1238; wrap_exp[1] = 32'h123C;
        wrap_exp[2] = 32'h1230; wrap_exp[3] = 32'h1234;
        sel = 1'b0; req = 1'b0; req_addr = '0;
        hready = 1'b1; hresp = 1'b0; hrdata = '0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_htrans", htrans, 2'b00);
        check("rst_haddr", haddr, 32'h0);
        check("rst_hburst", hburst, 3'b000);
        check("rst_line", line, 128'h0);
        check("rst_rdy", lr, 1'b0);
        check("rst_err", errs, 1'b0);
        check("rst_busy", busy, 1'b0);
        rst = 1'b1;
        @(negedge clk);

        // INCR4 zero wait
        run(32'h1238, 32'hA0, -1, 0, -1, -1, -1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t1_haddr%0d", i), ta[i], 32'h1230 + 32'(4*i));
            check($sformatf("t1_htrans%0d", i), tt[i], i == 0 ? 2'b10 : 2'b11);
        end
        check("t1_htrans_end", tt[4], 2'b00);
        check("t1_hburst", tbu[0], 3'b011);
        check("t1_hsize", bus0.HSIZE, 3'b010);
        check("t1_hwrite", bus0.HWRITE, 1'b0);
        check("t1_hprot", bus0.HPROT, 4'b0010);
        check("t1_lat", lat, 5);
        check("t1_line", line, 128'h000000A3_000000A2_000000A1_000000A0);
        check("t1_err", errs, 1'b0);
        check("t1_beats", nb, 4);
        end_req("t1");
        check("t1_line_kept", line, 128'h000000A3_000000A2_000000A1_000000A0);

        // WRAP4 critical word first
        sel = 1'b1;
        run(32'h1238, 32'hA0, -1, 0, -1, -1, -1);
        for (int i = 0; i < 4; i++)
            check($sformatf("t2_haddr%0d", i), ta[i], wrap_exp[i]);
        check("t2_hburst", tbu[0], 3'b010);
        check("t2_lat", lat, 5);
        check("t2_line", line, 128'h000000A3_000000A2_000000A1_000000A0);
        end_req("t2");
        sel = 1'b0;

        // two wait states on beat 2
        run(32'h2004, 32'hB0, 2, 2, -1, -1, -1);
        check("t3_haddr3", ta[3], 32'h200C);
        check("t3_haddr4", ta[4], 32'h200C);
        check("t3_haddr5", ta[5], 32'h200C);
        check("t3_htrans4", tt[4], 2'b11);
        check("t3_htrans5", tt[5], 2'b11);
        check("t3_htrans6", tt[6], 2'b00);
        check("t3_lat", lat, 7);
        check("t3_line", line, 128'h000000B3_000000B2_000000B1_000000B0);
        end_req("t3");

        // ERROR on beat 1
        run(32'h3000, 32'hC0, -1, 0, 1, -1, -1);
        check("t4_htrans_abort", tt[3], 2'b00);
        check("t4_lat", lat, 4);
        check("t4_err", errs, 1'b1);
        check("t4_beats", nb, 2);
        check("t4_line", line, 128'h000000B3_000000B2_000000B1_000000C0);
        end_req("t4");
        check("t4_err_clr", errs, 1'b0);

        // req held after line_ready
        run(32'h4010, 32'hD0, -1, 0, -1, -1, -1);
        check("t5_lat", lat, 5);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("t5_hold%0d", i), lr, 1'b1);
        end
        check("t5_line", line, 128'h000000D3_000000D2_000000D1_000000D0);
        end_req("t5");
        repeat (2) @(negedge clk);
        check("t5_no_burst", htrans, 2'b00);

        // req dropped at beat 2
        run(32'h5020, 32'hE0, -1, 0, -1, 2, -1);
        check("t5b_end", kend, 5);
        check("t5b_no_rdy", lat, -1);
        check("t5b_beats", nb, 4);
        check("t5b_line", line, 128'h000000E3_000000E2_000000E1_000000E0);

        // reset during beat 2
        run(32'h6038, 32'hF0, -1, 0, -1, -1, 3);
        check("t6_mid", tt[3], 2'b11);
        rst = 1'b0;
        #1;
        check("t6_rst_htrans", htrans, 2'b00);
        check("t6_rst_rdy", lr, 1'b0);
        check("t6_rst_busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        run(32'h6038, 32'hF0, -1, 0, -1, -1, -1);
        check("t6_haddr0", ta[0], 32'h6030);
        check("t6_htrans0", tt[0], 2'b10);
        check("t6_lat", lat, 5);
        check("t6_line", line, 128'h000000F3_000000F2_000000F1_000000F0);
        end_req("t6");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
